// File: rtl/servo_ramp_ctrl_if.sv
// Command handshake between a motion sequencer and servo_ramp_ctrl.
// One command = target angle plus dwell ticks, moved on valid && ready.
interface servo_ramp_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_angle;
    logic [7:0] cmd_hold;

    modport master (
        output cmd_valid,
        output cmd_angle,
        output cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_angle,
        input  cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/servo_ramp_ctrl.sv
// Servo position ramp controller: queues angle commands and slews
// the commanded angle at STEP degrees per tick, then dwells.
module servo_ramp_ctrl #(
    parameter int TICK_DIV  = 12000,
    parameter int STEP      = 1,
    parameter int MIN_ANGLE = 0,
    parameter int MAX_ANGLE = 180,
    parameter int HOME_POS  = 90,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    servo_ramp_ctrl_if.slave cmd,
    input  logic             abort,
    output logic [7:0]       angle,
    output logic             enable_mov,
    output logic             busy,
    output logic             done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [7:0]    MIN_A     = 8'(MIN_ANGLE);
    localparam logic [7:0]    MAX_A     = 8'(MAX_ANGLE);
    localparam logic [7:0]    HOME_A    = 8'(HOME_POS);
    localparam logic [7:0]    STEP8     = 8'(STEP);
    localparam logic [8:0]    STEP9     = 9'(STEP);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RAMP,
        HOLD
    } state_t;

    logic [TW-1:0] tcnt_q;
    logic          tick;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          rdy_en_q;

    logic [15:0]   head;
    logic [8:0]    d_lo;
    logic [8:0]    d_hi;
    logic [7:0]    tgt_clamp;

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    cur_q;
    logic [7:0]    cur_d;
    logic [7:0]    tgt_q;
    logic [7:0]    tgt_d;
    logic [7:0]    hold_q;
    logic [7:0]    hold_d;
    logic          done_q;
    logic          done_d;
    logic          hold_exit;
    logic [8:0]    sub;
    logic [8:0]    diff;

    assign tick  = (tcnt_q == TICK_LAST);
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    assign cmd.cmd_ready = rdy_en_q && !full && !abort;
    assign push          = cmd.cmd_valid && cmd.cmd_ready;

    assign angle      = cur_q;
    assign enable_mov = (state_q != IDLE);
    assign busy       = (state_q != IDLE) || !empty;
    assign done       = done_q;

    // Free-running tick divider, independent of the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else if (tick) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end

    // Holds cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    // FIFO payload storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cmd.cmd_angle, cmd.cmd_hold};
        end
    end

    // FIFO pointers and occupancy; abort flushes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Clamp the FIFO head target using borrow bits of 9-bit subtracts.
    always_comb begin
        head      = mem[rd_ptr_q];
        d_lo      = {1'b0, head[15:8]} - {1'b0, MIN_A};
        d_hi      = {1'b0, MAX_A} - {1'b0, head[15:8]};
        tgt_clamp = head[15:8];
        if (d_lo[8]) begin
            tgt_clamp = MIN_A;
        end else if (d_hi[8]) begin
            tgt_clamp = MAX_A;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= HOME_A;
            tgt_q   <= HOME_A;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    // Next state: load, slew toward target per tick, then dwell.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        tgt_d     = tgt_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        hold_exit = 1'b0;
        sub       = {1'b0, tgt_q} - {1'b0, cur_q};
        diff      = sub[8] ? (9'd0 - sub) : sub;
        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    pop     = 1'b1;
                    tgt_d   = tgt_clamp;
                    hold_d  = head[7:0];
                    state_d = RAMP;
                end
                RAMP: begin
                    if (tick) begin
                        if (diff <= STEP9) begin
                            cur_d   = tgt_q;
                            state_d = HOLD;
                        end else if (sub[8]) begin
                            cur_d = cur_q - STEP8;
                        end else begin
                            cur_d = cur_q + STEP8;
                        end
                    end
                end
                HOLD: begin
                    if (hold_q == 8'd0) begin
                        hold_exit = 1'b1;
                    end else if (tick) begin
                        hold_d    = hold_q - 8'd1;
                        hold_exit = (hold_q == 8'd1);
                    end
                    if (hold_exit) begin
                        done_d  = 1'b1;
                        state_d = empty ? IDLE : LOAD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: doc/servo_ramp_ctrl.md
SERVO_RAMP_CTRL -- requirements
Module: servo_ramp_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 12000, meaning clk cycles per ramp tick (1 ms at 12 MHz).
REQ-002 The block SHALL have parameter STEP, default 1, meaning maximum degrees moved per tick (1..255).
REQ-003 The block SHALL have parameter MIN_ANGLE, default 0, meaning the lowest commanded angle allowed.
REQ-004 The block SHALL have parameter MAX_ANGLE, default 180, meaning the highest commanded angle allowed.
REQ-005 The block SHALL have parameter HOME_POS, default 90, meaning the angle after reset.
REQ-006 The block SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of 2).
REQ-007 The block SHALL have port clk, input, 1 bit: the single system clock, 12 MHz, rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have port cmd_valid, input, 1 bit: a command is presented.
REQ-010 The block SHALL have port cmd_ready, output, 1 bit: a command can be accepted.
REQ-011 The block SHALL have port cmd_angle, input, 8 bits: target angle in degrees.
REQ-012 The block SHALL have port cmd_hold, input, 8 bits: dwell at target, in ticks.
REQ-013 The block SHALL have port abort, input, 1 bit: synchronous flush and stop.
REQ-014 The block SHALL have port angle, output, 8 bits: position to the servo PWM block.
REQ-015 The block SHALL have port enable_mov, output, 1 bit: movement enable to the servo PWM block.
REQ-016 The block SHALL have port busy, output, 1 bit: the state is not IDLE or the FIFO is not empty.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse when a command's dwell completes.

Function
REQ-018 The tick counter SHALL run freely from 0 to TICK_DIV-1 and pulse tick for one cycle at TICK_DIV-1; it SHALL NOT be reset by state changes.
REQ-019 A push SHALL occur on any clk edge with cmd_valid and cmd_ready high; cmd_ready SHALL equal !full && !abort.
REQ-020 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-021 The FSM SHALL use the states IDLE, LOAD, RAMP and HOLD.
REQ-022 IDLE SHALL move to LOAD when the FIFO is not empty.
REQ-023 LOAD SHALL pop one entry, clamp the target to [MIN_ANGLE, MAX_ANGLE], latch the hold value, and move to RAMP on the next cycle.
REQ-024 In RAMP, on each tick: if |target-cur| <= STEP then cur SHALL become target and the FSM SHALL move to HOLD; otherwise cur SHALL move by STEP toward target.
REQ-025 The difference |target-cur| SHALL be computed at 9 bits so that no wrap-around occurs, and cur SHALL never leave [MIN_ANGLE, MAX_ANGLE].
REQ-026 In HOLD, with hold = 0, the block SHALL exit on the next cycle.
REQ-027 In HOLD, with hold > 0, the block SHALL decrement hold on each tick and exit when it reaches 0.
REQ-028 On HOLD exit, done SHALL pulse for 1 cycle and the FSM SHALL go to LOAD if the FIFO is not empty, else IDLE.
REQ-029 angle SHALL be registered and equal cur.
REQ-030 enable_mov SHALL be 1 in LOAD, RAMP and HOLD, and 0 in IDLE, so the servo holds its last position.
REQ-031 When a command is accepted in IDLE with the FIFO empty at edge N: LOAD SHALL occur at N+1 and RAMP with enable_mov=1 at N+2.
REQ-032 When abort is high, the FIFO SHALL be flushed and the FSM SHALL go to IDLE on the next edge, with cur held and no done pulse.
REQ-033 A push presented in the same cycle as abort SHALL be dropped.

Reset
REQ-034 While rst_n=0 the outputs SHALL be angle=HOME_POS, enable_mov=0, done=0 and busy=0.
REQ-035 While rst_n=0 the internal state SHALL be: FIFO empty, FSM IDLE, tick counter 0, cur=HOME_POS.
REQ-036 cmd_ready SHALL be 1 from the first edge after release, and 0 while rst_n=0.
REQ-037 A reset asserted mid-ramp SHALL immediately return angle to HOME_POS and discard all commands.

Verification (TICK_DIV=4, STEP=1 unless noted)
REQ-038 Reset release -> angle=90, enable_mov=0, cmd_ready=1, busy=0.
REQ-039 Command (95, hold 2) -> angle moves 91, 92, 93, 94, 95 on successive ticks, then 2 ticks of dwell, a single-cycle done, then IDLE with enable_mov=0 and angle held at 95.
REQ-040 Command (250, 0) -> angle ramps to 180 and never exceeds it; done fires after the first cycle in HOLD.
REQ-041 Six back-to-back commands from IDLE -> 5 accepted; cmd_ready low on the 6th until the first command completes its dwell.
REQ-042 Abort while at 93 ramping to 120 with 2 commands queued -> next cycle IDLE, FIFO empty, angle=93, enable_mov=0, no done.
REQ-043 STEP=4, command (97, 0) from 90 -> angle 94, then 97 on the next tick, then done.
